// File: rtl/seg_pkg.sv
// Shared 7-segment pattern table, segment bit map and capture FSM states.
// Used by the hex encoder and the seg_capture readback decoder.
package seg_pkg;

  // Active-low a..g in bits 7..1, dp (bit 0) off.
  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D,
    8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1,
    8'h63, 8'h85, 8'h61, 8'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } cap_state_t;

endpackage

// File: rtl/seg_pat_decode.sv
// 7-bit active-low segment pattern (a..g) to {legal, blank, hex}.
// Ports: i_pat pattern in; o_legal table hit; o_blank all off; o_hex value.
module seg_pat_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic       o_legal,
  output logic       o_blank,
  output logic [3:0] o_hex
);

  always_comb begin
    o_legal = 1'b0;
    o_hex   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i_pat == SEG_HEX[i][SEG_A:SEG_G]) begin
        o_legal = 1'b1;
        o_hex   = 4'(i);
      end
    end
  end

  assign o_blank = (i_pat == SEG_BLANK[SEG_A:SEG_G]);

endmodule

// File: rtl/seg_capture.sv
// Readback decoder for the multiplexed 7-segment bus: debounces scan
// samples, decodes settled patterns per digit, pulses upd on each commit.
// Ports: clk, rst_n; seg_in/an_in active-low bus; digits/dp/valid/err
// per-digit state; upd/upd_idx commit pulse; an_err multi-anode pulse.
module seg_capture
  import seg_pkg::*;
#(
  parameter int NDIG       = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   an_in,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   err,
  output logic              upd,
  output logic [3:0]        upd_idx,
  output logic              an_err
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYC);

  logic [7:0]        r_seg_q, r_seg_p;
  logic [NDIG-1:0]   r_an_q, r_an_p;
  cap_state_t        r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic [4*NDIG-1:0] r_digits;
  logic [NDIG-1:0]   r_dp, r_valid, r_err;
  logic              r_upd, r_an_err;
  logic [3:0]        r_upd_idx;

  logic [NDIG-1:0]   w_inv, w_lo;
  logic              w_ok, w_multi, w_same;
  logic              w_commit;
  logic [3:0]        w_idx;
  logic              w_legal, w_blank;
  logic [3:0]        w_hex;

  // Clearing the lowest set bit of the inverted anodes leaves
  // something only when two or more anodes are active.
  assign w_inv   = ~r_an_q;
  assign w_lo    = w_inv & (w_inv - NDIG'(1));
  assign w_ok    = (w_inv != '0) && (w_lo == '0);
  assign w_multi = (w_lo != '0);
  assign w_same  = (r_seg_q == r_seg_p) && (r_an_q == r_an_p);

  // The counted sample sits in the _p registers during the commit
  // cycle, so a change arriving now cannot corrupt the commit.
  assign w_commit = (r_state == TRACK) && (r_cnt == CMAX);

  always_comb begin
    w_idx = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (!r_an_p[i]) w_idx = 4'(i);
    end
  end

  seg_pat_decode u_dec (
    .i_pat   (r_seg_p[SEG_A:SEG_G]),
    .o_legal (w_legal),
    .o_blank (w_blank),
    .o_hex   (w_hex)
  );

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_ok) begin
          w_state_n = TRACK;
          w_cnt_n   = CW'(1);
        end
      end
      TRACK: begin
        if (!w_ok) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else if (!w_same) begin
          w_cnt_n   = CW'(1);
        end else if (w_commit) begin
          w_state_n = HOLD;
        end else begin
          w_cnt_n   = (r_cnt == CMAX) ? r_cnt : r_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!w_ok) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else if (!w_same) begin
          w_state_n = TRACK;
          w_cnt_n   = CW'(1);
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q <= SEG_BLANK;
      r_seg_p <= SEG_BLANK;
      r_an_q  <= '1;
      r_an_p  <= '1;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_seg_q <= seg_in;
      r_seg_p <= r_seg_q;
      r_an_q  <= an_in;
      r_an_p  <= r_an_q;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits  <= '0;
      r_dp      <= '0;
      r_valid   <= '0;
      r_err     <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= 4'h0;
      r_an_err  <= 1'b0;
    end else begin
      r_upd     <= w_commit;
      r_upd_idx <= w_commit ? w_idx : 4'h0;
      r_an_err  <= w_multi;
      for (int i = 0; i < NDIG; i++) begin
        if (w_commit && !r_an_p[i]) begin
          r_dp[i] <= ~r_seg_p[SEG_DP];
          if (w_legal) begin
            r_digits[4*i +: 4] <= w_hex;
            r_valid[i]         <= 1'b1;
            r_err[i]           <= 1'b0;
          end else if (w_blank) begin
            r_digits[4*i +: 4] <= 4'h0;
            r_valid[i]         <= 1'b0;
            r_err[i]           <= 1'b0;
          end else begin
            r_valid[i]         <= 1'b0;
            r_err[i]           <= 1'b1;
          end
        end
      end
    end
  end

  assign digits  = r_digits;
  assign dp      = r_dp;
  assign valid   = r_valid;
  assign err     = r_err;
  assign upd     = r_upd;
  assign upd_idx = r_upd_idx;
  assign an_err  = r_an_err;

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
Readback decoder for the team's multiplexed 7-segment display bus, the inverse of the hex-to-segment encoder. It watches the active-low segment lines and the active-low digit-select lines and filters out scan glitches with a stability counter. It then converts each settled pattern back to a 4-bit hex value per digit position. It sits beside the display driver in self-checking top levels and in board-loopback tests, and presents decoded digits, flags and an update pulse to a checker or UART dumper.

Parameters:
NDIG, 8, number of digit positions (an_in width); legal range 1..16.
STABLE_CYC, 4, consecutive identical samples required before commit; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
seg_in  input  8  active-low segments: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
an_in  input  NDIG  active-low digit select; exactly one bit low selects a digit.
digits  output  4*NDIG  decoded hex; digit i occupies bits [4i+3:4i].
dp  output  NDIG  active-high decimal point per digit, taken from seg_in[0]==0.
valid  output  NDIG  digit i holds a legal hex decode.
err  output  NDIG  the last commit on digit i had an illegal pattern.
upd  output  1  one-cycle pulse on each commit.
upd_idx  output  4  index of the committed digit; valid only while upd=1.
an_err  output  1  one-cycle pulse when more than one an_in bit is low on a sampled cycle.

Behaviour:
- Reset, asynchronous on rst_n low: digits=0, dp=0, valid=0, err=0, upd=0, upd_idx=0, an_err=0. Internal sample registers reset to seg=8'hFF and an=all-ones. Counter is cleared and the FSM enters IDLE. The block resumes on the first clk edge after rst_n rises. A reset during TRACK abandons the partial count; nothing is committed.
- Input stage: seg_in and an_in are registered once every cycle into seg_q and an_q. All decisions use the registered values.
- an_q is one-hot-low (ok) when exactly one bit is 0. When two or more bits are 0, an_err pulses in the following cycle.
- FSM states:
  - IDLE: waits for ok. On ok, cnt=1 and the FSM moves to TRACK.
  - TRACK: if (seg_q, an_q) equals the previous sample and ok holds, cnt increments. When cnt reaches STABLE_CYC, the block commits on the next edge and moves to HOLD. If the sample differs and ok holds, cnt=1 and the FSM stays in TRACK, restarting with the new value. If ok is lost, the FSM returns to IDLE.
  - HOLD: the FSM stays while the sample is unchanged, so a steady input produces exactly one commit. When the sample changes with ok, cnt=1 and the FSM moves to TRACK. When ok is lost, the FSM moves to IDLE.
- Commit for digit i, the zero bit of an_q:
  - upd=1 and upd_idx=i for exactly one cycle.
  - dp[i] is set to ~seg_q[0].
  - Legal pattern: digits[i] is set to the decoded value, valid[i]=1, err[i]=0.
  - Blank pattern (seg_q[7:1]=7'h7F): digits[i]=0, valid[i]=0, err[i]=0.
  - Any other pattern: digits[i] is unchanged, valid[i]=0, err[i]=1.
  - Only digit i is modified.
- Decode compares seg_q[7:1] only. The 7-bit patterns are:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Latency: if seg_in and an_in are constant and legal from clk edge k onward, digits, valid and upd are visible after edge k+STABLE_CYC+1. With STABLE_CYC=4 that is 5 cycles.
- Simultaneous events: a change on the commit edge is sampled normally. The commit uses the stable value and the new value starts TRACK at cnt=1. an_err and a commit never coincide, because a commit requires ok.
- Width rule: cnt is $clog2(STABLE_CYC+1) bits and saturates; it never wraps.

Decomposition:
- Package seg_pkg holds:
  - localparams SEG_HEX[0:15], the 8-bit active-low patterns with dp off (0=8'h03, 1=8'h9F, A=8'h11, F=8'h71).
  - SEG_BLANK=8'hFF.
  - segment bit indices SEG_A..SEG_DP.
  - the FSM state enum {IDLE, TRACK, HOLD}.
- Sub-module seg_pat_decode: a combinational mapping from the 7-bit pattern to {legal, blank, hex[3:0]}. Both the hex-to-segment encoder and this block use the same package table.

Test Plan:
- Reset mid-operation: hold rst_n=0 for 3 cycles during TRACK with a partial count, then release; all outputs are 0 and no upd appears.
- Single digit: seg_in=8'h11 (A) and an_in=8'hFE held 10 cycles with STABLE_CYC=4. One upd pulse appears 5 cycles after the change, with upd_idx=0, digits[3:0]=4'hA, valid[0]=1, dp[0]=0, and no further pulses.
- Scan sweep: drive 8 digits cycling 0..7, 6 cycles each, with the matching SEG_HEX value and dp low (bit0=0) on digit 3. Result: digits=32'h76543210, valid=8'hFF, dp=8'h08, and 8 upd pulses in total.
- Glitch filter: pattern 8'h9F for 2 cycles, then 8'h25 (2) held 6 cycles on an_in=8'hFD. Only one commit occurs, with digits[7:4]=2.
- Illegal and blank: 8'h13 held on digit 1 after a legal 2 gives err[1]=1, valid[1]=0 and digits[7:4] still 2. A following 8'hFF gives err[1]=0, valid[1]=0 and digits[7:4]=0.
- Anode fault: an_in=8'hFC for 8 cycles gives one an_err pulse per sampled cycle (8 pulses), no upd, and outputs unchanged. an_in=8'hFF gives no an_err and no upd.
